rcn_slave_buf: RTL and testbench

Responder-side rcn ring node with 4-entry request and response buffering. Captures request words addressed to its window from `rcn_in` and presents them one at a time to a local target over a cs/ack handshake. Returns each completion to the originating master as a response word, injected into the first free ring slot. It is the target-side counterpart of the buffered rcn master and sits on the same 69-bit ring.

---
 rtl/rcn_slave_buf.sv | 154 +++++++++++++++
 tb/tb_rcn_slave_buf.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rcn_slave_buf.sv
// rcn_slave_buf: target-side node on the 69-bit rcn ring.
// Captures requests addressed to its window, queues them for a local target
// (cs/ack handshake), and puts each completion back on the ring as a
// response word in the first free slot. A 4-deep credit counter limits the
// number of requests in flight, so the response queue can never overflow.
module rcn_slave_buf #(
  parameter logic [23:0] ADDR_BASE = 24'h000000,
  parameter logic [23:0] ADDR_MASK = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [68:0] rcn_in,
  output logic [68:0] rcn_out,
  output logic        cs,
  output logic        wr,
  output logic [3:0]  mask,
  output logic [23:0] addr,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic [31:0] rdata
);

  // Queue entries hold the ring word without valid/pending:
  // wr[66] id[65:60] mask[59:56] addr[55:34] seq[33:32] data[31:0]
  localparam int ENTRY_W = 67;

  logic [ENTRY_W-1:0] req_mem_q  [4];
  logic [ENTRY_W-1:0] resp_mem_q [4];

  logic [1:0]  req_wptr_q,  req_wptr_d;
  logic [1:0]  req_rptr_q,  req_rptr_d;
  logic [2:0]  req_cnt_q,   req_cnt_d;
  logic [1:0]  resp_wptr_q, resp_wptr_d;
  logic [1:0]  resp_rptr_q, resp_rptr_d;
  logic [2:0]  resp_cnt_q,  resp_cnt_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic [68:0] rcn_out_q,   rcn_out_d;

  logic               in_valid;
  logic               in_is_req;
  logic [23:0]        in_byte_addr;
  logic               match;
  logic               accept;
  logic               req_empty;
  logic               req_pop;
  logic [ENTRY_W-1:0] req_head;
  logic [ENTRY_W-1:0] resp_entry;
  logic               resp_nonempty;
  logic               inject;

  assign in_valid     = rcn_in[68];
  assign in_is_req    = rcn_in[68] & rcn_in[67];
  assign in_byte_addr = {rcn_in[55:34], 2'b00};
  assign match        = in_is_req &&
                        ((in_byte_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  // outstanding never exceeds 4, so bit 2 set means no credit left
  assign accept       = match && !outstanding_q[2];

  assign req_empty    = (req_cnt_q == 3'd0);
  assign req_head     = req_mem_q[req_rptr_q];
  assign req_pop      = !req_empty && ack;

  // Writes return their own data; reads return the target's rdata
  assign resp_entry   = {req_head[66:32], req_head[66] ? req_head[31:0] : rdata};

  assign resp_nonempty = (resp_cnt_q != 3'd0);
  // A slot is free when it is empty or when we are consuming it this cycle
  assign inject        = resp_nonempty && (!in_valid || accept);

  // Local request port: driven straight from the queue head, zero when idle
  always_comb begin
    cs    = !req_empty;
    wr    = 1'b0;
    mask  = 4'h0;
    addr  = 24'h000000;
    wdata = 32'h00000000;
    if (!req_empty) begin
      wr    = req_head[66];
      mask  = req_head[59:56];
      addr  = {req_head[55:34], 2'b00};
      wdata = req_head[31:0];
    end
  end

  // Next-state for both queues, the credit counter and the ring output
  always_comb begin
    req_wptr_d    = req_wptr_q;
    req_rptr_d    = req_rptr_q;
    req_cnt_d     = req_cnt_q;
    resp_wptr_d   = resp_wptr_q;
    resp_rptr_d   = resp_rptr_q;
    resp_cnt_d    = resp_cnt_q;
    outstanding_d = outstanding_q;
    rcn_out_d     = rcn_in;

    if (accept)  req_wptr_d = req_wptr_q + 2'd1;
    if (req_pop) req_rptr_d = req_rptr_q + 2'd1;
    case ({accept, req_pop})
      2'b10:   req_cnt_d = req_cnt_q + 3'd1;
      2'b01:   req_cnt_d = req_cnt_q - 3'd1;
      default: req_cnt_d = req_cnt_q;
    endcase

    if (req_pop) resp_wptr_d = resp_wptr_q + 2'd1;
    if (inject)  resp_rptr_d = resp_rptr_q + 2'd1;
    case ({req_pop, inject})
      2'b10:   resp_cnt_d = resp_cnt_q + 3'd1;
      2'b01:   resp_cnt_d = resp_cnt_q - 3'd1;
      default: resp_cnt_d = resp_cnt_q;
    endcase

    // Credit is returned only once the response has actually left
    case ({accept, inject})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (inject)      rcn_out_d = {1'b1, 1'b0, resp_mem_q[resp_rptr_q]};
    else if (accept) rcn_out_d = 69'd0;
  end

  // Control state; reset discards everything in flight and clears the ring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wptr_q    <= 2'd0;
      req_rptr_q    <= 2'd0;
      req_cnt_q     <= 3'd0;
      resp_wptr_q   <= 2'd0;
      resp_rptr_q   <= 2'd0;
      resp_cnt_q    <= 3'd0;
      outstanding_q <= 3'd0;
      rcn_out_q     <= 69'd0;
    end else begin
      req_wptr_q    <= req_wptr_d;
      req_rptr_q    <= req_rptr_d;
      req_cnt_q     <= req_cnt_d;
      resp_wptr_q   <= resp_wptr_d;
      resp_rptr_q   <= resp_rptr_d;
      resp_cnt_q    <= resp_cnt_d;
      outstanding_q <= outstanding_d;
      rcn_out_q     <= rcn_out_d;
    end
  end

  // Queue storage; contents need no reset because the counts gate all reads
  always_ff @(posedge clk) begin
    if (accept)  req_mem_q[req_wptr_q]   <= rcn_in[66:0];
    if (req_pop) resp_mem_q[resp_wptr_q] <= resp_entry;
  end

  assign rcn_out = rcn_out_q;

endmodule

// File: tb/tb_rcn_slave_buf.sv
// Testbench for rcn_slave_buf: table of per-cycle vectors for the basic
// read/write/pass-through flows, then hand-written multi-cycle sequences
// for back-pressure, slot contention and mid-operation reset.
module tb_rcn_slave_buf;

  logic        clk;
  logic        rst_n;
  logic [68:0] rcn_in;
  logic [68:0] rcn_out;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  int n_checks;
  int n_errors;

  rcn_slave_buf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rcn_in  (rcn_in),
    .rcn_out (rcn_out),
    .cs      (cs),
    .wr      (wr),
    .mask    (mask),
    .addr    (addr),
    .wdata   (wdata),
    .ack     (ack),
    .rdata   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [68:0] rin;
    logic        ack;
    logic [31:0] rdata;
    logic [68:0] xout;
    logic        xcs;
    logic        xwr;
    logic [3:0]  xmask;
    logic [23:0] xaddr;
    logic [31:0] xwdata;
  } vec_t;

  function automatic logic [68:0] mk_req(input logic w, input logic [5:0] id,
      input logic [3:0] m, input logic [23:0] a, input logic [1:0] sq,
      input logic [31:0] d);
    return {1'b1, 1'b1, w, id, m, a[23:2], sq, d};
  endfunction

  function automatic logic [68:0] mk_rsp(input logic w, input logic [5:0] id,
      input logic [3:0] m, input logic [23:0] a, input logic [1:0] sq,
      input logic [31:0] d);
    return {1'b1, 1'b0, w, id, m, a[23:2], sq, d};
  endfunction

  function automatic vec_t mkv(input logic [68:0] rin, input logic a,
      input logic [31:0] rd, input logic [68:0] xo, input logic xc,
      input logic xw, input logic [3:0] xm, input logic [23:0] xa,
      input logic [31:0] xd);
    vec_t v;
    v.rin = rin; v.ack = a; v.rdata = rd; v.xout = xo; v.xcs = xc;
    v.xwr = xw; v.xmask = xm; v.xaddr = xa; v.xwdata = xd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [68:0] xo, input logic xc,
      input logic xw, input logic [3:0] xm, input logic [23:0] xa, input logic [31:0] xd);
    chk({tag, " rcn_out"}, rcn_out, xo);
    chk({tag, " cs"},      69'(cs),    69'(xc));
    chk({tag, " wr"},      69'(wr),    69'(xw));
    chk({tag, " mask"},    69'(mask),  69'(xm));
    chk({tag, " addr"},    69'(addr),  69'(xa));
    chk({tag, " wdata"},   69'(wdata), 69'(xd));
    $display("%s: rcn_in=%h ack=%b -> rcn_out=%h cs=%b addr=%h", tag, rcn_in, ack, rcn_out, cs, addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];
  logic [68:0] qreq [5];
  logic [68:0] qrsp [5];
  logic [68:0] r_w, w_w, n_w, p_w, a_w, b_w, x_w, n1_w, n3_w;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    rcn_in = 69'd0;
    ack    = 1'b0;
    rdata  = 32'd0;

    r_w = mk_req(1'b0, 6'd5, 4'hF, 24'h001234, 2'd2, 32'h0);
    w_w = mk_req(1'b1, 6'd9, 4'h3, 24'h000100, 2'd1, 32'h12345678);
    n_w = mk_req(1'b0, 6'd3, 4'hF, 24'h200000, 2'd0, 32'h11);
    p_w = mk_rsp(1'b1, 6'd7, 4'hF, 24'h001000, 2'd3, 32'h55);
    a_w = mk_req(1'b0, 6'd1, 4'hF, 24'h000010, 2'd0, 32'h0);
    b_w = mk_req(1'b1, 6'd2, 4'h1, 24'h000020, 2'd1, 32'hCAFE);

    tbl[0]  = mkv(r_w,   1'b0, 32'h0,        69'd0, 1'b1, 1'b0, 4'hF, 24'h001234, 32'h0);
    tbl[1]  = mkv(69'd0, 1'b1, 32'hDEADBEEF, 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[2]  = mkv(69'd0, 1'b0, 32'h0,
                  mk_rsp(1'b0, 6'd5, 4'hF, 24'h001234, 2'd2, 32'hDEADBEEF),
                  1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[3]  = mkv(69'd0, 1'b1, 32'hBAD,      69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[4]  = mkv(w_w,   1'b0, 32'h0,        69'd0, 1'b1, 1'b1, 4'h3, 24'h000100, 32'h12345678);
    tbl[5]  = mkv(69'd0, 1'b1, 32'hAAAA5555, 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[6]  = mkv(69'd0, 1'b0, 32'h0,
                  mk_rsp(1'b1, 6'd9, 4'h3, 24'h000100, 2'd1, 32'h12345678),
                  1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[7]  = mkv(n_w,   1'b0, 32'h0, n_w,   1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[8]  = mkv(p_w,   1'b0, 32'h0, p_w,   1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[9]  = mkv(69'd0, 1'b0, 32'h0, 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[10] = mkv(a_w,   1'b0, 32'h0,   69'd0, 1'b1, 1'b0, 4'hF, 24'h000010, 32'h0);
    tbl[11] = mkv(b_w,   1'b1, 32'h111, 69'd0, 1'b1, 1'b1, 4'h1, 24'h000020, 32'hCAFE);
    tbl[12] = mkv(69'd0, 1'b1, 32'h222,
                  mk_rsp(1'b0, 6'd1, 4'hF, 24'h000010, 2'd0, 32'h111),
                  1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[13] = mkv(69'd0, 1'b0, 32'h0,
                  mk_rsp(1'b1, 6'd2, 4'h1, 24'h000020, 2'd1, 32'hCAFE),
                  1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tbl[14] = mkv(69'd0, 1'b0, 32'h0, 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);

    // Reset state
    #1;
    check_outs("reset_async", 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tick();
    tick();
    check_outs("reset_held", 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    rst_n = 1'b1;

    // Table-driven per-cycle vectors
    for (int i = 0; i < 15; i++) begin
      rcn_in = tbl[i].rin;
      ack    = tbl[i].ack;
      rdata  = tbl[i].rdata;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].xout, tbl[i].xcs, tbl[i].xwr,
                 tbl[i].xmask, tbl[i].xaddr, tbl[i].xwdata);
    end

    // Back-pressure: 5 requests with no ack; the 5th must circulate
    for (int k = 0; k < 5; k++) begin
      qreq[k] = mk_req(1'b0, 6'(10 + k), 4'hF, 24'(24'h40 + 4 * k), 2'(k), 32'h0);
      qrsp[k] = mk_rsp(1'b0, 6'(10 + k), 4'hF, 24'(24'h40 + 4 * k), 2'(k), 32'(32'h100 + k));
    end
    ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rcn_in = qreq[k];
      tick();
      check_outs($sformatf("bp_fill%0d", k), (k < 4) ? 69'd0 : qreq[4],
                 1'b1, 1'b0, 4'hF, 24'h000040, 32'h0);
    end
    rcn_in = 69'd0; ack = 1'b1; rdata = 32'h100;
    tick();
    check_outs("bp_ack0", 69'd0, 1'b1, 1'b0, 4'hF, 24'h000044, 32'h0);
    ack = 1'b0;
    tick();
    check_outs("bp_inj0", qrsp[0], 1'b1, 1'b0, 4'hF, 24'h000044, 32'h0);
    rcn_in = qreq[4];
    tick();
    check_outs("bp_resend", 69'd0, 1'b1, 1'b0, 4'hF, 24'h000044, 32'h0);
    rcn_in = 69'd0;
    for (int k = 1; k < 5; k++) begin
      ack = 1'b1; rdata = 32'(32'h100 + k);
      tick();
      check_outs($sformatf("bp_drain%0d", k), (k == 1) ? 69'd0 : qrsp[k - 1],
                 (k < 4), 1'b0, (k < 4) ? 4'hF : 4'h0,
                 (k < 4) ? 24'(24'h40 + 4 * (k + 1)) : 24'h0, 32'h0);
    end
    ack = 1'b0;
    tick();
    check_outs("bp_inj4", qrsp[4], 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);

    // Slot contention: response waits for the first empty slot
    x_w  = mk_req(1'b0, 6'd20, 4'hF, 24'h000080, 2'd3, 32'h0);
    n1_w = mk_req(1'b0, 6'd21, 4'hF, 24'h300000, 2'd0, 32'h1);
    n3_w = mk_req(1'b1, 6'd23, 4'h4, 24'h010000, 2'd2, 32'h3);
    rcn_in = x_w;
    tick();
    check_outs("ct_req", 69'd0, 1'b1, 1'b0, 4'hF, 24'h000080, 32'h0);
    rcn_in = n1_w; ack = 1'b1; rdata = 32'h77;
    tick();
    check_outs("ct_n1", n1_w, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    rcn_in = p_w; ack = 1'b0;
    tick();
    check_outs("ct_p", p_w, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    rcn_in = n3_w;
    tick();
    check_outs("ct_n3", n3_w, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    rcn_in = 69'd0;
    tick();
    check_outs("ct_inj", mk_rsp(1'b0, 6'd20, 4'hF, 24'h000080, 2'd3, 32'h77),
               1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tick();
    check_outs("ct_idle", 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);

    // Reset mid-operation with 3 requests queued
    for (int k = 0; k < 3; k++) begin
      rcn_in = mk_req(1'b1, 6'(30 + k), 4'hF, 24'(24'h100 + 4 * k), 2'd0, 32'(32'hA0 + k));
      tick();
      check_outs($sformatf("rs_fill%0d", k), 69'd0, 1'b1, 1'b1, 4'hF, 24'h000100, 32'hA0);
    end
    rcn_in = 69'd0;
    #2 rst_n = 1'b0;
    #1;
    check_outs("rs_async", 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_outs("rs_after", 69'd0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      qreq[k] = mk_req(1'b0, 6'(40 + k), 4'hF, 24'(24'h200 + 4 * k), 2'd0, 32'h0);
      rcn_in = qreq[k];
      tick();
      check_outs($sformatf("rs_req%0d", k), (k < 4) ? 69'd0 : qreq[4],
                 1'b1, 1'b0, 4'hF, 24'h000200, 32'h0);
    end
    rcn_in = 69'd0; ack = 1'b1; rdata = 32'hBEEF0000;
    tick();
    check_outs("rs_ack", 69'd0, 1'b1, 1'b0, 4'hF, 24'h000204, 32'h0);
    ack = 1'b0;
    tick();
    check_outs("rs_inj", mk_rsp(1'b0, 6'd40, 4'hF, 24'h000200, 2'd0, 32'hBEEF0000),
               1'b1, 1'b0, 4'hF, 24'h000204, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
